jb_cntr_arb: RTL and testbench
==============================

// Module: jb_cntr_arb
// PURPOSE
//  Time-shares one jb_cntr interval counter among NUM_REQ requesters.
//  Each requester asks for an interval of (len+1) clk cycles. The block grants the counter to one requester, loads it, runs it to len, then pulses that requester's done.
//  Sits between the NCO/timing users and the shared jb_cntr instance.
// PARAMETERS
//  NUM_REQ      4    number of requesters, 2..16
//  COUNT_WIDTH  39   counter and interval width, matches jb_cntr
// PORTS
//  clk      in   1                    clock
//  resetn   in   1                    synchronous, active-low reset
//  req      in   NUM_REQ              per-requester request level; held until done or dropped to abort
//  req_len  in   NUM_REQ*COUNT_WIDTH  per-requester terminal count; slice i = [i*COUNT_WIDTH +: COUNT_WIDTH]
//  grant    out  NUM_REQ              one-hot owner of the counter; all zero when idle
//  done     out  NUM_REQ              one-cycle pulse to the owner when its interval completes
//  busy     out  1                    high in RUN and DONE
//  cntr     out  COUNT_WIDTH          live counter value; 0 outside RUN
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, done=0, busy=0, cntr=0, len_q=0, rr pointer=0.
//  FSM states IDLE, RUN and DONE; the state type is in the package.
//  IDLE:
//   - If |req in cycle t, the arbiter picks a winner w.
//   - The block latches grant=onehot(w) and len_q=req_len[w], and goes to RUN at t+1 with cntr=0.
//  RUN:
//   - The counter is enabled every cycle and increments by 1.
//   - When cntr==len_q, the next state is DONE.
//   - len_q is frozen for the whole grant; req_len changes are ignored.
//  DONE:
//   - done[w]=1 for exactly one cycle; grant is still held in this cycle.
//   - The next state is IDLE, with grant=0 and cntr=0.
//  Grant duration is len+2 cycles. len=0 gives 1 RUN cycle.
//   - Example: req at t, RUN at t+1, done at t+2.
//  Abort:
//   - If req[w] drops in RUN, the block goes to IDLE next cycle.
//   - There is no done pulse, the counter clears, and the rr pointer still advances.
//  Requesters must drop req in the DONE cycle. If req is still high in IDLE, it is treated as a new request.
//  Re-arbitration takes at least 1 IDLE cycle between grants; there is no back-to-back grant.
//  New requests arriving during RUN/DONE wait; they are not lost while held.
//  Wrap-around: the counter never exceeds len_q. len_q = all-ones is legal and runs 2^COUNT_WIDTH cycles.
//  Reset asserted mid-RUN returns everything to reset values next clk. No done pulse is issued.
// CONFIGURATION
//  JB_CNTR_ARB_RR_EN defined:
//   - Round-robin arbitration.
//   - The search starts at the index after the last winner (including aborted winners).
//  JB_CNTR_ARB_RR_EN undefined:
//   - Fixed priority; the lowest index wins.
//   - The rr pointer logic is removed.
// STRUCTURE
//  Package jb_cntr_arb_pkg:
//   - state_t enum {IDLE, RUN, DONE}
//   - MAX_REQ=16 constant
//   - function onehot_first(req, start)
//  Sub-module: one jb_cntr instance.
//   - enable = (state==RUN)
//   - max_value = len_q
//   - resetn = resetn & (state==RUN)
//   - Its cntr drives the cntr port.
//  The arbiter and FSM are local to jb_cntr_arb.
// TESTING
//  1. Reset, then req=4'b0001, len0=5:
//     grant0 at t+1; cntr 0..5; done0 at t+7; grant=0 at t+8.
//  2. len=0 on req2:
//     1 RUN cycle; done2 at t+2; cntr stays 0.
//  3. req=4'b1111 held, each requester dropping req on its done, RR_EN on, all len=2:
//     grant order 0,1,2,3,0; 1 idle cycle between grants.
//  4. Same as 3 with RR_EN off:
//     grants 0,1,2,3 in order; a re-raised req0 pre-empts 3 at the next IDLE.
//  5. Abort: req1 granted with len=100, req1 drops at cntr=10:
//     IDLE next cycle; done=0; cntr=0; pending req2 granted after that.
//  6. Reset mid-RUN at cntr=7:
//     grant=0, busy=0, cntr=0 next cycle; no done pulse.

Source files
------------

// File: rtl/jb_cntr_arb_pkg.sv
// Shared types and helpers for the jb_cntr time-sharing arbiter.
package jb_cntr_arb_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int unsigned MAX_REQ = 16;

    // One-hot of the first set bit of req[num-1:0], searching upward from start with wrap.
    function automatic logic [MAX_REQ-1:0] onehot_first(input logic [MAX_REQ-1:0] req,
                                                         input int unsigned      start,
                                                         input int unsigned      num);
        logic [MAX_REQ-1:0] oh;
        int unsigned        idx;
        oh = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = start + i;
            if (idx >= num) idx = idx - num;
            if (i < num && oh == '0 && req[idx[3:0]]) oh[idx[3:0]] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/jb_cntr.sv
// Interval counter: counts 0..max_value while enabled, wrapping to 0 after max_value.
module jb_cntr #(
    parameter int unsigned COUNT_WIDTH = 39
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [COUNT_WIDTH-1:0] max_value,
    output logic [COUNT_WIDTH-1:0] cntr
);

    logic [COUNT_WIDTH-1:0] cntr_q, cntr_d;

    always_comb begin
        cntr_d = cntr_q;
        if (enable) cntr_d = (cntr_q == max_value) ? '0 : cntr_q + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) cntr_q <= '0;
        else         cntr_q <= cntr_d;
    end

    assign cntr = cntr_q;

endmodule

// File: rtl/jb_cntr_arb.sv
// Time-shares one jb_cntr among NUM_REQ requesters (IDLE -> RUN -> DONE per grant).
// JB_CNTR_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority, lowest index wins.
module jb_cntr_arb
    import jb_cntr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned COUNT_WIDTH = 39
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_len,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           busy,
    output logic [COUNT_WIDTH-1:0]         cntr
);

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [COUNT_WIDTH-1:0] len_q, len_d;
    logic [MAX_REQ-1:0]     req_ext, pick;
    logic [3:0]             start, win_idx;
    logic [COUNT_WIDTH-1:0] win_len, cntr_raw;
    logic                   owner_req;
    logic                   unused_bits;

`ifdef JB_CNTR_ARB_RR_EN
    logic [3:0] rr_q, rr_d;

    // Pointer advances on every grant, aborted ones included.
    always_comb begin
        rr_d = rr_q;
        if (state_q == IDLE && |req) begin
            rr_d = (win_idx == 4'(NUM_REQ - 1)) ? 4'd0 : win_idx + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) rr_q <= '0;
        else         rr_q <= rr_d;
    end

    assign start = rr_q;
`else
    assign start = '0;
`endif

    always_comb begin
        req_ext = '0;
        for (int i = 0; i < NUM_REQ; i++) req_ext[i] = req[i];
        pick    = onehot_first(req_ext, 32'(start), NUM_REQ);
        win_idx = '0;
        win_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                win_idx = 4'(i);
                win_len = req_len[i*COUNT_WIDTH +: COUNT_WIDTH];
            end
        end
        owner_req = |(req & grant_q);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        len_d   = len_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = RUN;
                    grant_d = pick[NUM_REQ-1:0];
                    len_d   = win_len;
                end
            end
            RUN: begin
                // A dropped request aborts even on the terminal count cycle.
                if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (cntr_raw == len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            len_q   <= len_d;
        end
    end

    jb_cntr #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_cntr (
        .clk      (clk),
        .resetn   (resetn & (state_q == RUN)),
        .enable   (state_q == RUN),
        .max_value(len_q),
        .cntr     (cntr_raw)
    );

    // After an abort the counter clears one cycle late, so mask it outside RUN.
    assign cntr        = (state_q == RUN) ? cntr_raw : '0;
    assign grant       = grant_q;
    assign done        = (state_q == DONE) ? grant_q : '0;
    assign busy        = (state_q != IDLE);
    assign unused_bits = ^{pick, win_idx};

endmodule

// File: tb/tb_jb_cntr_arb.sv
// Self-checking bench for jb_cntr_arb: table vectors, corner sequences and a random model run.
module tb_jb_cntr_arb;

    localparam int unsigned N = 4;
    localparam int unsigned W = 39;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_len;
    logic [N-1:0]   grant, done;
    logic           busy;
    logic [W-1:0]   cntr;

    int checks   = 0;
    int failures = 0;

    // Transaction-level reference: owner index, position within the grant, latched length.
    int              m_owner = -1;
    longint unsigned m_pos   = 0;
    longint unsigned m_len   = 0;
    int              m_rr    = 0;

    jb_cntr_arb #(
        .NUM_REQ    (N),
        .COUNT_WIDTH(W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .req_len(req_len),
        .grant  (grant),
        .done   (done),
        .busy   (busy),
        .cntr   (cntr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        int           len;
        int           win;
    } vec_t;

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int first_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_len(input int i, input longint unsigned l);
        req_len[i*W +: W] = W'(l);
    endtask

    task automatic model_step();
        if (!resetn) begin
            m_owner = -1;
            m_pos   = 0;
            m_rr    = 0;
        end else if (m_owner < 0) begin
            if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_rr + k) % N;
                    if (req[i]) begin
                        m_owner = i;
                        break;
                    end
                end
                m_len = longint'(req_len[m_owner*W +: W]);
                m_pos = 0;
`ifdef JB_CNTR_ARB_RR_EN
                m_rr  = (m_owner + 1) % N;
`endif
            end
        end else if (m_pos == m_len + 1) begin
            m_owner = -1;
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else begin
            m_pos++;
        end
    endtask

    task automatic check_model();
        logic [N-1:0] eg, ed;
        logic         eb;
        logic [W-1:0] ec;
        eg = '0;
        ed = '0;
        eb = 1'b0;
        ec = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            eb          = 1'b1;
            if (m_pos <= m_len) ec = W'(m_pos);
            else                ed[m_owner] = 1'b1;
        end
        checks++;
        if (grant !== eg || done !== ed || busy !== eb || cntr !== ec) begin
            failures++;
            $display("FAIL model t=%0t got grant=%b done=%b busy=%b cntr=%0d exp grant=%b done=%b busy=%b cntr=%0d",
                     $time, grant, done, busy, cntr, eg, ed, eb, ec);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
        end
    endtask

    // One clock: model consumes the inputs at the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        req     = '0;
        req_len = '0;
        cyc();
        cyc();
        resetn = 1'b1;
    endtask

    task automatic wait_cntr(input longint unsigned val, input string name);
        int b;
        b = 0;
        while (cntr != W'(val) && b < 300) begin
            cyc();
            b++;
        end
        chk(name, 64'(cntr), 64'(val));
    endtask

    initial begin
        vec_t tbl[6];
        int   order[$];
        int   exp_order[5];
        int   cnum, done_cyc, w;
        logic [N-1:0] prevg;
        logic raised;

        tbl[0] = '{req: 4'b0001, len: 5, win: 0};
        tbl[1] = '{req: 4'b0100, len: 0, win: 2};
        tbl[2] = '{req: 4'b0110, len: 3, win: 1};
        tbl[3] = '{req: 4'b1000, len: 1, win: 3};
        tbl[4] = '{req: 4'b1010, len: 2, win: 1};
        tbl[5] = '{req: 4'b1111, len: 4, win: 0};

        do_reset();
        chk("rst_grant", 64'(grant), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_cntr", 64'(cntr), 0);

        // Single grants from reset: the pointer is 0, so lowest index wins in either mode.
        for (int e = 0; e < 6; e++) begin
            do_reset();
            req = tbl[e].req;
            for (int i = 0; i < N; i++) set_len(i, longint'(tbl[e].len));
            cyc();
            chk("vec_grant", 64'(grant), 64'(oh(tbl[e].win)));
            chk("vec_cntr0", 64'(cntr), 0);
            for (int k = 1; k <= tbl[e].len; k++) begin
                cyc();
                chk("vec_cntr", 64'(cntr), 64'(k));
            end
            cyc();
            chk("vec_done", 64'(done), 64'(oh(tbl[e].win)));
            chk("vec_busy_done", 64'(busy), 1);
            req = '0;
            cyc();
            chk("vec_release", 64'(grant), 0);
            chk("vec_idle_cntr", 64'(cntr), 0);
        end

        // Grant order with all requesting; req0 re-raised when requester 2 is granted.
`ifdef JB_CNTR_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 1, 2, 0, 3};
`endif
        do_reset();
        for (int i = 0; i < N; i++) set_len(i, 2);
        req      = 4'b1111;
        prevg    = '0;
        raised   = 1'b0;
        cnum     = 0;
        done_cyc = -1;
        while (order.size() < 5 && cnum < 200) begin
            cyc();
            cnum++;
            if (grant != '0 && prevg == '0) begin
                w = first_idx(grant);
                order.push_back(w);
                if (done_cyc >= 0) chk("order_gap", 64'(cnum - done_cyc), 2);
                if (w == 2 && !raised) begin
                    req[0] = 1'b1;
                    raised = 1'b1;
                end
            end
            if (done != '0) begin
                done_cyc = cnum;
                req      = req & ~done;
            end
            prevg = grant;
        end
        chk("order_count", 64'(order.size()), 5);
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            chk("order", 64'(order[i]), 64'(exp_order[i]));
        end

        // Abort: requester 1 drops mid-interval, pending requester 2 follows.
        do_reset();
        set_len(1, 100);
        set_len(2, 3);
        req = 4'b0110;
        cyc();
        chk("abort_grant", 64'(grant), 64'(oh(1)));
        wait_cntr(10, "abort_wait");
        req[1] = 1'b0;
        cyc();
        chk("abort_grant0", 64'(grant), 0);
        chk("abort_done", 64'(done), 0);
        chk("abort_cntr", 64'(cntr), 0);
        chk("abort_busy", 64'(busy), 0);
        cyc();
        chk("abort_next", 64'(grant), 64'(oh(2)));
        chk("abort_next_cntr", 64'(cntr), 0);
        req = '0;
        cyc();
        cyc();

        // Reset asserted mid-interval.
        do_reset();
        set_len(0, 20);
        req = 4'b0001;
        cyc();
        wait_cntr(7, "rst_wait");
        resetn = 1'b0;
        cyc();
        chk("mrst_grant", 64'(grant), 0);
        chk("mrst_busy", 64'(busy), 0);
        chk("mrst_cntr", 64'(cntr), 0);
        chk("mrst_done", 64'(done), 0);
        resetn = 1'b1;
        req    = '0;
        cyc();

        // Random traffic against the model, including aborts, length churn and resets.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) set_len($urandom_range(0, N - 1), $urandom_range(0, 6));
            if (grant != '0 && $urandom_range(0, 15) == 0) req = req & ~grant;
            if (done != '0) req = req & ~done;
            resetn = ($urandom_range(0, 99) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
